// File: rtl/ciclo_fetch_pkg.sv
// ciclo_fetch_pkg: shared word width, PC step and fetch FSM encoding
package ciclo_fetch_pkg;
  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;
endpackage

// File: rtl/ciclo_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load and flush; flush wins and only drops valid
module if_id_reg #(
  parameter int XLEN = ciclo_fetch_pkg::XLEN,
  parameter int STEP = ciclo_fetch_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] d_inst,
  input  logic [XLEN-1:0] d_pc,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid   <= 1'b0;
      inst    <= '0;
      pc      <= '0;
      pc_next <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      inst    <= d_inst;
      pc      <= d_pc;
      pc_next <= d_pc + XLEN'(STEP);
    end
endmodule

// File: rtl/ciclo_fetch.sv
// ciclo_fetch: PC register, fetch FSM and IF/ID stage in front of an external combinational instruction memory
module ciclo_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = ciclo_fetch_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic [31:0] DirInst,
  input  logic [31:0] InstS,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_next,
  output logic [31:0] fetch_count,
  output logic [1:0]  state
);
  import ciclo_fetch_pkg::*;
  state_t          st, st_d;
  logic [XLEN-1:0] pc, pc_d;
  logic            advance, flush;
  assign advance = (st == RUN) && (!id_valid || id_ready) && !redirect_valid;
  assign flush   = redirect_valid || ((st == HALT) && id_ready);
  assign DirInst = pc;
  assign state   = st;
  always_comb begin
    st_d = st;
    pc_d = redirect_valid ? {redirect_addr[XLEN-1:2], 2'b00} : advance ? pc + XLEN'(PC_STEP) : pc;
    case (st)
      IDLE:    st_d = start ? RUN : IDLE;
      RUN:     st_d = halt ? HALT : RUN;
      HALT:    st_d = (start && !halt) ? RUN : HALT;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st          <= IDLE;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      st          <= st_d;
      pc          <= pc_d;
      fetch_count <= fetch_count + XLEN'(advance);
    end
  if_id_reg #(.XLEN(XLEN), .STEP(PC_STEP)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (advance),
    .flush   (flush),
    .d_inst  (InstS),
    .d_pc    (pc),
    .valid   (id_valid),
    .inst    (id_inst),
    .pc      (id_pc),
    .pc_next (id_pc_next)
  );
endmodule

// File: tb/tb_ciclo_fetch.sv
// tb_ciclo_fetch: directed vectors against a word-index instruction memory model
module tb_ciclo_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, halt, redirect_valid, id_ready;
  logic [31:0] redirect_addr, DirInst, InstS, id_inst, id_pc, id_pc_next, fetch_count;
  logic        id_valid;
  logic [1:0]  state;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign InstS = DirInst >> 2;

  ciclo_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .DirInst(DirInst), .InstS(InstS), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_next(id_pc_next),
    .fetch_count(fetch_count), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; id_ready = 1'b0;
    #12;
    check("rst_pc", DirInst, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_inst", id_inst, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_hold", 32'(state), 32'd0);
    check("idle_valid", 32'(id_valid), 32'd0);
    start = 1'b1; id_ready = 1'b1;
    step();
    start = 1'b0;
    check("run_state", 32'(state), 32'd1);
    check("run_nofetch", fetch_count, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("seq_inst%0d", k), id_inst, 32'(k));
      check($sformatf("seq_pc%0d", k), id_pc, 32'(4 * k));
      check($sformatf("seq_pcn%0d", k), id_pc_next, 32'(4 * k + 4));
      check($sformatf("seq_cnt%0d", k), fetch_count, 32'(k + 1));
    end
    check("seq_dir", DirInst, 32'd16);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_inst", id_inst, 32'd3);
      check("stall_pc", id_pc, 32'd12);
      check("stall_dir", DirInst, 32'd16);
      check("stall_cnt", fetch_count, 32'd4);
    end
    id_ready = 1'b1;
    step();
    check("resume_inst", id_inst, 32'd4);
    check("resume_pc", id_pc, 32'd16);
    check("resume_cnt", fetch_count, 32'd5);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h0000_000B;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(id_valid), 32'd0);
    check("redir_dir", DirInst, 32'd8);
    check("redir_cnt", fetch_count, 32'd5);
    step();
    check("redir_inst", id_inst, 32'd2);
    check("redir_pc", id_pc, 32'd8);
    check("redir_cnt2", fetch_count, 32'd6);
    check("redir_v2", 32'(id_valid), 32'd1);
    halt = 1'b1;
    step();
    check("halt_state", 32'(state), 32'd2);
    check("halt_dir", DirInst, 32'd12);
    check("halt_valid", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    step();
    check("halt_clr", 32'(id_valid), 32'd0);
    check("halt_dir2", DirInst, 32'd12);
    check("halt_start_blk", 32'(state), 32'd2);
    halt = 1'b0; id_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("rerun_state", 32'(state), 32'd1);
    check("rerun_dir", DirInst, 32'd12);
    id_ready = 1'b1;
    step();
    check("rerun_inst", id_inst, 32'd3);
    check("rerun_cnt", fetch_count, 32'd7);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("hadv_state", 32'(state), 32'd2);
    check("hadv_inst", id_inst, 32'd4);
    check("hadv_cnt", fetch_count, 32'd8);
    check("hadv_dir", DirInst, 32'd20);
    start = 1'b1;
    step();
    start = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'd12;
    step();
    redirect_valid = 1'b0;
    check("pre_rst_dir", DirInst, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_dir", DirInst, 32'd0);
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_valid", 32'(id_valid), 32'd0);
    check("mrst_cnt", fetch_count, 32'd0);
    check("mrst_inst", id_inst, 32'd0);
    check("mrst_pcn", id_pc_next, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_state", 32'(state), 32'd0);
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("idle_redir_dir", DirInst, 32'hFFFF_FFFC);
    check("idle_redir_state", 32'(state), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("wrap_dir", DirInst, 32'd0);
    check("wrap_pcn", id_pc_next, 32'd0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_inst", id_inst, 32'h3FFF_FFFF);
    check("wrap_cnt", fetch_count, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
